// File: rtl/mips_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mips_pkg: types and constants shared by fetch and control units    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mips_pkg;
  typedef logic [5:0] opcode_t;
  typedef logic [5:0] funct_t;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] DEF_HALT_ADDR    = 32'h0000_0000;

  localparam opcode_t OPC_RTYPE = 6'h00;
  localparam opcode_t OPC_J     = 6'h02;
  localparam opcode_t OPC_BEQ   = 6'h04;
endpackage
`default_nettype wire

// File: rtl/mips_pc_next.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mips_pc_next: next-PC select (pc / redirect / pending) + halt flag |
// | Build option: MIPS_FETCH_DELAY_SLOT_EN. Rev 1.0                    |
// +--------------------------------------------------------------------+
module mips_pc_next
  import mips_pkg::*;
#(
  parameter logic [31:0] HALT_ADDR = DEF_HALT_ADDR
) (
  input  logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
`ifdef MIPS_FETCH_DELAY_SLOT_EN
  input  logic        pend_valid,
  input  logic [31:0] pend_target,
  output logic        pend_load,
  output logic [31:0] pend_value,
`endif
  output logic [31:0] next_pc,
  output logic        halt
);
  logic [31:0] target_aligned;

  assign target_aligned = redirect_target & 32'hFFFF_FFFC;

`ifdef MIPS_FETCH_DELAY_SLOT_EN
  // A pending target always wins over a redirect seen during the slot.
  assign next_pc    = pend_valid ? pend_target : pc;
  assign pend_load  = redirect_valid & ~pend_valid;
  assign pend_value = target_aligned;
`else
  assign next_pc    = redirect_valid ? target_aligned : pc;
`endif

  assign halt = (next_pc == HALT_ADDR);
endmodule
`default_nettype wire

// File: rtl/mips_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mips_fetch_unit: PC + Avalon-style fetch, valid/ready to decode    |
// | Build option: MIPS_FETCH_DELAY_SLOT_EN (branch delay slot). Rev 1.0|
// +--------------------------------------------------------------------+
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = DEF_HALT_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_address,
  output logic        mem_read,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        active
);
  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  next_pc;
  logic         halt_next;
  logic         handshake;
  logic         read_done;

  assign mem_address = pc;
  assign opcode      = instr[31:26];
  assign funct       = instr[5:0];
  assign handshake   = instr_valid & instr_ready;
  // Only a request we actually issued can complete; stray readdata is dropped.
  assign read_done   = mem_read & ~mem_waitrequest;

`ifdef MIPS_FETCH_DELAY_SLOT_EN
  logic        pend_valid;
  logic        pend_load;
  logic [31:0] pend_target;
  logic [31:0] pend_value;

  mips_pc_next #(.HALT_ADDR(HALT_ADDR)) u_pc_next (
    .pc              (pc),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pend_valid      (pend_valid),
    .pend_target     (pend_target),
    .pend_load       (pend_load),
    .pend_value      (pend_value),
    .next_pc         (next_pc),
    .halt            (halt_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else if (state == S_HOLD && handshake) begin
      pend_valid <= pend_load;
      if (pend_load) pend_target <= pend_value;
    end
  end
`else
  mips_pc_next #(.HALT_ADDR(HALT_ADDR)) u_pc_next (
    .pc              (pc),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .next_pc         (next_pc),
    .halt            (halt_next)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FETCH;
      pc          <= RESET_VECTOR;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      mem_read    <= 1'b0;
      active      <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          active <= 1'b1;
          if (read_done) begin
            instr       <= mem_readdata;
            instr_pc    <= pc;
            pc          <= pc + 32'd4;
            mem_read    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= S_HOLD;
          end else begin
            mem_read <= 1'b1;
          end
        end
        S_HOLD: begin
          if (handshake) begin
            instr_valid <= 1'b0;
            if (halt_next) begin
              state    <= S_HALT;
              active   <= 1'b0;
              mem_read <= 1'b0;
            end else begin
              pc       <= next_pc;
              mem_read <= 1'b1;
              state    <= S_FETCH;
            end
          end
        end
        S_HALT: begin
          active      <= 1'b0;
          mem_read    <= 1'b0;
          instr_valid <= 1'b0;
        end
        default: state <= S_HALT;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mips_fetch_unit.sv
`default_nettype none
// tb_mips_fetch_unit: table-driven vectors plus hand sequences for
// redirect, halt and mid-read reset.
module tb_mips_fetch_unit;
  localparam logic [31:0] RV   = 32'hBFC0_0000;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
  localparam logic [31:0] D0   = 32'h2008_0005;
  localparam logic [31:0] D1   = 32'h0000_0020;
  localparam logic [31:0] D2   = 32'h1000_0003;
  localparam logic [31:0] D3   = 32'h0800_0040;
  localparam logic [31:0] D4   = 32'h03E0_0008;
  localparam logic [31:0] D5   = 32'h8C43_0004;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        active;

  int checks   = 0;
  int failures = 0;

  mips_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_waitrequest (mem_waitrequest),
    .mem_readdata    (mem_readdata),
    .instr           (instr),
    .opcode          (opcode),
    .funct           (funct),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .active          (active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [31:0] rd;
    logic        rdy;
    logic        rv;
    logic [31:0] rt;
    logic        e_rd;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic        e_act;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic e_rd, input logic [31:0] e_addr,
                           input logic e_v, input logic [31:0] e_instr,
                           input logic [31:0] e_ipc, input logic e_act);
    logic [31:0] ei;
    ei = e_instr;
    chk({tag, ".mem_read"},    {31'd0, mem_read},    {31'd0, e_rd});
    chk({tag, ".mem_address"}, mem_address,          e_addr);
    chk({tag, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, e_v});
    chk({tag, ".instr"},       instr,                ei);
    chk({tag, ".instr_pc"},    instr_pc,             e_ipc);
    chk({tag, ".active"},      {31'd0, active},      {31'd0, e_act});
    chk({tag, ".opcode"},      {26'd0, opcode},      {26'd0, ei[31:26]});
    chk({tag, ".funct"},       {26'd0, funct},       {26'd0, ei[5:0]});
  endtask

  task automatic drive(input logic w, input logic [31:0] rd, input logic rdy,
                       input logic rv, input logic [31:0] rt);
    mem_waitrequest = w;
    mem_readdata    = rd;
    instr_ready     = rdy;
    redirect_valid  = rv;
    redirect_target = rt;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] exp_a;
    logic [31:0] li;
    logic [31:0] lpc;
    logic [31:0] ha;

    //          w    rd    rdy  rv    rt     e_rd  e_addr    e_v   e_instr e_ipc   e_act
    vecs[0]  = '{1'b0, JUNK, 1'b0, 1'b0, 32'h0, 1'b1, RV,        1'b0, 32'h0, 32'h0,   1'b1};
    vecs[1]  = '{1'b0, D0,   1'b0, 1'b0, 32'h0, 1'b0, RV+32'h4,  1'b1, D0,    RV,      1'b1};
    vecs[2]  = '{1'b0, JUNK, 1'b1, 1'b0, 32'h0, 1'b1, RV+32'h4,  1'b0, D0,    RV,      1'b1};
    vecs[3]  = '{1'b1, JUNK, 1'b0, 1'b0, 32'h0, 1'b1, RV+32'h4,  1'b0, D0,    RV,      1'b1};
    vecs[4]  = '{1'b1, JUNK, 1'b0, 1'b0, 32'h0, 1'b1, RV+32'h4,  1'b0, D0,    RV,      1'b1};
    vecs[5]  = '{1'b1, JUNK, 1'b0, 1'b0, 32'h0, 1'b1, RV+32'h4,  1'b0, D0,    RV,      1'b1};
    vecs[6]  = '{1'b0, D1,   1'b0, 1'b0, 32'h0, 1'b0, RV+32'h8,  1'b1, D1,    RV+32'h4, 1'b1};
    vecs[7]  = '{1'b0, JUNK, 1'b0, 1'b1, 32'h0, 1'b0, RV+32'h8,  1'b1, D1,    RV+32'h4, 1'b1};
    vecs[8]  = '{1'b0, JUNK, 1'b0, 1'b0, 32'h0, 1'b0, RV+32'h8,  1'b1, D1,    RV+32'h4, 1'b1};
    vecs[9]  = '{1'b0, JUNK, 1'b0, 1'b1, 32'h0, 1'b0, RV+32'h8,  1'b1, D1,    RV+32'h4, 1'b1};
    vecs[10] = '{1'b0, JUNK, 1'b0, 1'b0, 32'h0, 1'b0, RV+32'h8,  1'b1, D1,    RV+32'h4, 1'b1};
    vecs[11] = '{1'b0, JUNK, 1'b0, 1'b0, 32'h0, 1'b0, RV+32'h8,  1'b1, D1,    RV+32'h4, 1'b1};
    vecs[12] = '{1'b0, JUNK, 1'b1, 1'b0, 32'h0, 1'b1, RV+32'h8,  1'b0, D1,    RV+32'h4, 1'b1};
    vecs[13] = '{1'b0, D2,   1'b0, 1'b1, 32'h0, 1'b0, RV+32'hC,  1'b1, D2,    RV+32'h8, 1'b1};

    reset = 1'b1;
    drive(1'b0, JUNK, 1'b0, 1'b0, 32'h0);
    repeat (3) tick();
    check_out("reset", 1'b0, RV, 1'b0, 32'h0, 32'h0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].w, vecs[i].rd, vecs[i].rdy, vecs[i].rv, vecs[i].rt);
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].e_rd, vecs[i].e_addr, vecs[i].e_v,
                vecs[i].e_instr, vecs[i].e_ipc, vecs[i].e_act);
    end

    // Redirect at the handshake of the instruction fetched from RV+8.
`ifdef MIPS_FETCH_DELAY_SLOT_EN
    exp_a = RV + 32'hC;
`else
    exp_a = RV + 32'h100;
`endif
    drive(1'b0, JUNK, 1'b1, 1'b1, RV + 32'h101);
    tick();
    check_out("redir", 1'b1, exp_a, 1'b0, D2, RV + 32'h8, 1'b1);
    drive(1'b0, D3, 1'b0, 1'b0, 32'h0);
    tick();
    check_out("redir_fetch", 1'b0, exp_a + 32'h4, 1'b1, D3, exp_a, 1'b1);
    li  = D3;
    lpc = exp_a;
`ifdef MIPS_FETCH_DELAY_SLOT_EN
    drive(1'b0, JUNK, 1'b1, 1'b1, 32'h0);
    tick();
    check_out("slot_hs", 1'b1, RV + 32'h100, 1'b0, D3, RV + 32'hC, 1'b1);
    drive(1'b0, D4, 1'b0, 1'b0, 32'h0);
    tick();
    check_out("target_fetch", 1'b0, RV + 32'h104, 1'b1, D4, RV + 32'h100, 1'b1);
    li  = D4;
    lpc = RV + 32'h100;
`endif

    // Jump to the halt address.
    drive(1'b0, JUNK, 1'b1, 1'b1, 32'h0);
    tick();
`ifdef MIPS_FETCH_DELAY_SLOT_EN
    check_out("jr_hs", 1'b1, RV + 32'h104, 1'b0, li, lpc, 1'b1);
    drive(1'b0, D5, 1'b0, 1'b0, 32'h0);
    tick();
    check_out("jr_slot", 1'b0, RV + 32'h108, 1'b1, D5, RV + 32'h104, 1'b1);
    drive(1'b0, JUNK, 1'b1, 1'b0, 32'h0);
    tick();
    li  = D5;
    lpc = RV + 32'h104;
    ha  = RV + 32'h108;
`else
    ha = RV + 32'h104;
`endif
    check_out("halt", 1'b0, ha, 1'b0, li, lpc, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, JUNK, 1'b1, 1'b1, RV);
      tick();
      check_out($sformatf("halted%0d", k), 1'b0, ha, 1'b0, li, lpc, 1'b0);
    end

    // Reset while a read is stalled.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, JUNK, 1'b0, 1'b0, 32'h0);
    tick();
    check_out("rst2_req", 1'b1, RV, 1'b0, 32'h0, 32'h0, 1'b1);
    drive(1'b0, D5, 1'b0, 1'b0, 32'h0);
    tick();
    check_out("rst2_cap", 1'b0, RV + 32'h4, 1'b1, D5, RV, 1'b1);
    drive(1'b0, JUNK, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b1, JUNK, 1'b0, 1'b0, 32'h0);
    tick();
    check_out("stall", 1'b1, RV + 32'h4, 1'b0, D5, RV, 1'b1);
    reset = 1'b1;
    drive(1'b1, D0, 1'b0, 1'b0, 32'h0);
    tick();
    check_out("mid_rst", 1'b0, RV, 1'b0, 32'h0, 32'h0, 1'b0);
    reset = 1'b0;
    drive(1'b0, D1, 1'b0, 1'b0, 32'h0);
    tick();
    check_out("post_rst", 1'b1, RV, 1'b0, 32'h0, 32'h0, 1'b1);
    drive(1'b0, D2, 1'b0, 1'b0, 32'h0);
    tick();
    check_out("post_rst_cap", 1'b0, RV + 32'h4, 1'b1, D2, RV, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
